vga_timing_controller: RTL and testbench



---
 rtl/vga_timing_pkg.sv | 32 +++
 rtl/vga_pixel_tick.sv | 39 +++
 rtl/vga_timing_controller.sv | 158 +++++++++++++++
 tb/tb_vga_timing_controller.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster timing, counter width and scan-out state type
// for the VGA timing controller.
package vga_timing_pkg;

    localparam int unsigned CNT_W = 16;

    localparam int unsigned H_VISIBLE_DEF = 640;
    localparam int unsigned H_FRONT_DEF   = 16;
    localparam int unsigned H_SYNC_DEF    = 96;
    localparam int unsigned H_BACK_DEF    = 48;
    localparam int unsigned V_VISIBLE_DEF = 480;
    localparam int unsigned V_FRONT_DEF   = 10;
    localparam int unsigned V_SYNC_DEF    = 2;
    localparam int unsigned V_BACK_DEF    = 33;

    localparam int unsigned H_TOTAL_DEF = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
    localparam int unsigned V_TOTAL_DEF = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // True when v lies in the half-open window [lo, lo+len).
    function automatic logic in_window(input logic [CNT_W-1:0] v,
                                       input int unsigned lo,
                                       input int unsigned len);
        return (32'(v) >= lo) && (32'(v) < lo + len);
    endfunction

endpackage

// File: rtl/vga_pixel_tick.sv
// Pixel-tick divider: tick_o is high for the cycle the count sits at CLK_DIV-1.
module vga_pixel_tick #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    // Tick is registered from the next count so it lines up with cnt_q.
    always_comb begin
        cnt_d  = cnt_q + DIV_W'(1);
        if (clear_i || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
        tick_d = en_i && (cnt_d == LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/vga_timing_controller.sv
// VGA raster sequencer with frame-aligned start/stop.
// Optional macro VGA_FRAME_COUNT_EN adds a 16-bit frame_count output.
module vga_timing_controller
    import vga_timing_pkg::*;
#(
    parameter int unsigned CLK_DIV         = 4,
    parameter int unsigned H_VISIBLE       = H_VISIBLE_DEF,
    parameter int unsigned H_FRONT         = H_FRONT_DEF,
    parameter int unsigned H_SYNC          = H_SYNC_DEF,
    parameter int unsigned H_BACK          = H_BACK_DEF,
    parameter int unsigned V_VISIBLE       = V_VISIBLE_DEF,
    parameter int unsigned V_FRONT         = V_FRONT_DEF,
    parameter int unsigned V_SYNC          = V_SYNC_DEF,
    parameter int unsigned V_BACK          = V_BACK_DEF,
    parameter bit          SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    output logic             pixel_tick,
    output logic [CNT_W-1:0] pixel_x,
    output logic [CNT_W-1:0] pixel_y,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic             line_start,
    output logic             frame_start,
    output logic             active
`ifdef VGA_FRAME_COUNT_EN
    ,
    output logic [CNT_W-1:0] frame_count
`endif
);

    localparam int unsigned H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HS_START = H_VISIBLE + H_FRONT;
    localparam int unsigned VS_START = V_VISIBLE + V_FRONT;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
    logic             prime_q, prime_d;
    logic             line_start_q, line_start_d;
    logic             frame_start_q, frame_start_d;
    logic             hsync_q, hsync_d, vsync_q, vsync_d;
    logic             video_on_q, video_on_d;
    logic             active_q, active_d;
    logic             tick, x_last, y_last, line_wrap, frame_wrap;
    logic             div_clear, div_en;

    assign div_clear = (state_q == IDLE) || (state_d == IDLE);
    assign div_en    = (state_d != IDLE);

    vga_pixel_tick #(
        .CLK_DIV(CLK_DIV)
    ) u_pixel_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear_i(div_clear),
        .en_i   (div_en),
        .tick_o (tick)
    );

    // prime_q marks "raster not yet started": the first tick lands on (0,0).
    always_comb begin
        x_last     = (x_q == CNT_W'(H_TOTAL - 1));
        y_last     = (y_q == CNT_W'(V_TOTAL - 1));
        line_wrap  = tick && (prime_q || x_last);
        frame_wrap = tick && (prime_q || (x_last && y_last));

        state_d = state_q;
        case (state_q)
            IDLE:    if (run) state_d = RUN;
            RUN:     if (!run) state_d = DRAIN;
            DRAIN: begin
                if (frame_wrap) state_d = IDLE;
                else if (run)   state_d = RUN;
            end
            default: state_d = IDLE;
        endcase

        x_d     = x_q;
        y_d     = y_q;
        prime_d = prime_q;
        if (state_d == IDLE) begin
            x_d     = '0;
            y_d     = '0;
            prime_d = 1'b1;
        end else if (tick) begin
            prime_d = 1'b0;
            if (line_wrap) begin
                x_d = '0;
                y_d = (prime_q || y_last) ? '0 : y_q + CNT_W'(1);
            end else begin
                x_d = x_q + CNT_W'(1);
            end
        end

        // Decoded from next-state counters so they align with pixel_x/pixel_y.
        active_d      = (state_d != IDLE);
        line_start_d  = line_wrap && active_d;
        frame_start_d = frame_wrap && active_d;
        video_on_d    = active_d && (32'(x_d) < H_VISIBLE) && (32'(y_d) < V_VISIBLE);
        hsync_d       = in_window(x_d, HS_START, H_SYNC) ^ SYNC_ACTIVE_LOW;
        vsync_d       = in_window(y_d, VS_START, V_SYNC) ^ SYNC_ACTIVE_LOW;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            x_q           <= '0;
            y_q           <= '0;
            prime_q       <= 1'b1;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            hsync_q       <= SYNC_ACTIVE_LOW;
            vsync_q       <= SYNC_ACTIVE_LOW;
            video_on_q    <= 1'b0;
            active_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            prime_q       <= prime_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_on_q    <= video_on_d;
            active_q      <= active_d;
        end
    end

    assign pixel_tick  = tick;
    assign pixel_x     = x_q;
    assign pixel_y     = y_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = video_on_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign active      = active_q;

`ifdef VGA_FRAME_COUNT_EN
    logic [CNT_W-1:0] frame_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
        end else if (frame_start_d) begin
            frame_cnt_q <= frame_cnt_q + CNT_W'(1);
        end
    end

    assign frame_count = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_controller.sv
// Randomized run/stop/reset stimulus on a shrunken raster, checked every cycle
// against a frame-position reference model.
module tb_vga_timing_controller;

    localparam int CLK_DIV = 3;
    localparam int HV = 6, HF = 2, HSY = 3, HB = 2;
    localparam int VV = 4, VF = 2, VSY = 2, VB = 1;
    localparam int HT = HV + HF + HSY + HB;
    localparam int VT = VV + VF + VSY + VB;
    localparam int FRAME = HT * VT;
    localparam int HS0 = HV + HF;
    localparam int VS0 = VV + VF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        run = 1'b0;
    logic        pixel_tick, hsync, vsync, video_on, line_start, frame_start, active;
    logic [15:0] pixel_x, pixel_y;
`ifdef VGA_FRAME_COUNT_EN
    logic [15:0] frame_count;
`endif

    always #5 clk = ~clk;

    vga_timing_controller #(
        .CLK_DIV(CLK_DIV),
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSY), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VB),
        .SYNC_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .run(run),
        .pixel_tick(pixel_tick), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .hsync(hsync), .vsync(vsync), .video_on(video_on),
        .line_start(line_start), .frame_start(frame_start), .active(active)
`ifdef VGA_FRAME_COUNT_EN
        , .frame_count(frame_count)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got=%0d expected=%0d", tag, $time, got, exp);
        end
    endtask

    // Model: m_pos is the linear raster position, -1 before the first tick.
    bit m_on = 1'b0, m_drain = 1'b0, m_ls = 1'b0, m_fs = 1'b0, m_tick_now;
    int m_pos = -1, m_phase = 0, m_fc = 0, np;
    int n_frames = 0, n_stops = 0;

    function automatic int mx();
        return (m_pos < 0) ? 0 : m_pos % HT;
    endfunction

    function automatic int my();
        return (m_pos < 0) ? 0 : m_pos / HT;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_on = 1'b0; m_drain = 1'b0; m_ls = 1'b0; m_fs = 1'b0;
            m_pos = -1; m_phase = 0; m_fc = 0;
        end else begin
            m_tick_now = m_on && (m_phase == CLK_DIV - 1);
            m_ls = 1'b0;
            m_fs = 1'b0;
            if (!m_on) begin
                if (run) begin
                    m_on = 1'b1; m_drain = 1'b0; m_phase = 0; m_pos = -1;
                end
            end else begin
                if (m_tick_now) begin
                    np = (m_pos + 1) % FRAME;
                    if (m_drain && np == 0) begin
                        m_on = 1'b0;
                        m_pos = -1;
                        n_stops++;
                    end else begin
                        m_pos = np;
                        m_ls = ((np % HT) == 0);
                        m_fs = (np == 0);
                        if (m_fs) begin
                            m_fc = (m_fc + 1) % 65536;
                            n_frames++;
                        end
                    end
                end
                if (m_on) begin
                    m_phase = (m_phase + 1) % CLK_DIV;
                    m_drain = !run;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("tick", int'(pixel_tick), int'(m_on && (m_phase == CLK_DIV - 1)));
        check("x", int'(pixel_x), mx());
        check("y", int'(pixel_y), my());
        check("hsync", int'(hsync), (mx() >= HS0 && mx() < HS0 + HSY) ? 0 : 1);
        check("vsync", int'(vsync), (my() >= VS0 && my() < VS0 + VSY) ? 0 : 1);
        check("video_on", int'(video_on), int'(m_on && mx() < HV && my() < VV));
        check("line_start", int'(line_start), int'(m_ls));
        check("frame_start", int'(frame_start), int'(m_fs));
        check("active", int'(active), int'(m_on));
`ifdef VGA_FRAME_COUNT_EN
        check("frame_count", int'(frame_count), m_fc);
`endif
    end

    // Reset asserted between clock edges must take effect immediately.
    task automatic async_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_x", int'(pixel_x), 0);
        check("arst_y", int'(pixel_y), 0);
        check("arst_hsync", int'(hsync), 1);
        check("arst_vsync", int'(vsync), 1);
        check("arst_active", int'(active), 0);
        check("arst_tick", int'(pixel_tick), 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        bit found;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(negedge clk);

        #1 run = 1'b1;
        repeat (3 * FRAME * CLK_DIV + 20) @(negedge clk);
        #1 run = 1'b0;
        repeat (FRAME * CLK_DIV + 20) @(negedge clk);
        check("drained_idle", int'(active), 0);

        for (int i = 0; i < 90; i++) begin
            #1 run = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 0)
                repeat ($urandom_range(1, 4)) @(negedge clk);
            else
                repeat ($urandom_range(5, 300)) @(negedge clk);
            if ($urandom_range(0, 19) == 0) async_reset();
        end

        #1 run = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 3000 && !found; k++) begin
            @(negedge clk);
            found = (m_pos >= 0) && (mx() == HS0 + 1);
        end
        check("hsync_window_reached", int'(found), 1);
        check("pre_reset_hsync", int'(hsync), 0);
        async_reset();
        repeat (5) @(negedge clk);

        check("saw_frames", int'(n_frames > 3), 1);
        check("saw_drain_stop", int'(n_stops > 0), 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
